// File: rtl/sbh_cg_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : sbh_cg_sequencer
// Brief    : Per-4x4-group sign-bit-hiding controller. Scans 16 levels, issues
//            one decision request under a watchdog, and emits a group record.
//            Optional statistics counters are built when SBH_SEQ_STATS_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module sbh_cg_sequencer #(
  parameter int LEVEL_W        = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coef_valid,
  output logic               coef_ready,
  input  logic [LEVEL_W-1:0] coef_abs,
  input  logic               coef_sign,
  output logic               dec_valid_o,
  output logic [3:0]         dec_firstNZ_o,
  output logic [3:0]         dec_lastNZ_o,
  output logic               dec_parity_o,
  output logic               dec_sign_o,
  input  logic               dec_valid_i,
  input  logic               dec_needHide_i,
  output logic               grp_valid,
  input  logic               grp_ready,
  output logic               grp_needHide,
  output logic               grp_allzero,
  output logic               grp_err,
  output logic [3:0]         grp_hidePos,
  output logic [15:0]        stat_groups,
  output logic [15:0]        stat_hidden
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic            nz_seen_q, nz_seen_d;
  logic            parity_q, parity_d;
  logic [3:0]      first_q, first_d;
  logic [3:0]      last_q, last_d;
  logic            sign_q, sign_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            need_hide_q, need_hide_d;
  logic            allzero_q, allzero_d;
  logic            err_q, err_d;
  logic            coef_ready_q, coef_ready_d;
  logic            coef_nz;
  logic            accept;

  assign accept  = coef_valid && coef_ready_q;
  assign coef_nz = (coef_abs != '0);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    nz_seen_d    = nz_seen_q;
    parity_d     = parity_q;
    first_d      = first_q;
    last_d       = last_q;
    sign_d       = sign_q;
    wd_d         = wd_q;
    need_hide_d  = need_hide_q;
    allzero_d    = allzero_q;
    err_d        = err_q;
    coef_ready_d = coef_ready_q;
    dec_valid_o  = 1'b0;
    grp_valid    = 1'b0;

    case (state_q)
      S_SCAN: begin
        // coef_ready is registered so it stays low from the 16th accept onwards
        coef_ready_d = 1'b1;
        if (accept) begin
          idx_d    = idx_q + 4'd1;
          parity_d = parity_q ^ coef_abs[0];
          if (coef_nz) begin
            if (!nz_seen_q) begin
              first_d = idx_q;
            end
            nz_seen_d = 1'b1;
            last_d    = idx_q;
            sign_d    = coef_sign;
          end
          if (idx_q == 4'd15) begin
            idx_d        = 4'd0;
            coef_ready_d = 1'b0;
            need_hide_d  = 1'b0;
            if (nz_seen_q || coef_nz) begin
              state_d = S_ISSUE;
            end else begin
              state_d   = S_OUTPUT;
              allzero_d = 1'b1;
            end
          end
        end
      end

      S_ISSUE: begin
        dec_valid_o = 1'b1;
        wd_d        = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        // A response in the final watchdog cycle takes priority over the abort
        if (dec_valid_i) begin
          need_hide_d = dec_needHide_i;
          state_d     = S_OUTPUT;
        end else if (wd_q == WD_LIMIT) begin
          need_hide_d = 1'b0;
          err_d       = 1'b1;
          state_d     = S_OUTPUT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_OUTPUT: begin
        grp_valid = 1'b1;
        if (grp_ready) begin
          nz_seen_d    = 1'b0;
          parity_d     = 1'b0;
          err_d        = 1'b0;
          allzero_d    = 1'b0;
          need_hide_d  = 1'b0;
          coef_ready_d = 1'b1;
          state_d      = S_SCAN;
        end
      end

      default: begin
        state_d = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SCAN;
      idx_q        <= 4'd0;
      nz_seen_q    <= 1'b0;
      parity_q     <= 1'b0;
      first_q      <= 4'd0;
      last_q       <= 4'd0;
      sign_q       <= 1'b0;
      wd_q         <= '0;
      need_hide_q  <= 1'b0;
      allzero_q    <= 1'b0;
      err_q        <= 1'b0;
      coef_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      nz_seen_q    <= nz_seen_d;
      parity_q     <= parity_d;
      first_q      <= first_d;
      last_q       <= last_d;
      sign_q       <= sign_d;
      wd_q         <= wd_d;
      need_hide_q  <= need_hide_d;
      allzero_q    <= allzero_d;
      err_q        <= err_d;
      coef_ready_q <= coef_ready_d;
    end
  end

  assign coef_ready    = coef_ready_q;
  assign dec_firstNZ_o = first_q;
  assign dec_lastNZ_o  = last_q;
  assign dec_parity_o  = parity_q;
  assign dec_sign_o    = sign_q;
  assign grp_needHide  = need_hide_q;
  assign grp_allzero   = allzero_q;
  assign grp_err       = err_q;
  assign grp_hidePos   = need_hide_q ? first_q : 4'd0;

`ifdef SBH_SEQ_STATS_EN
  logic [15:0] stat_groups_q, stat_groups_d;
  logic [15:0] stat_hidden_q, stat_hidden_d;
  logic        rec_hs;

  assign rec_hs = (state_q == S_OUTPUT) && grp_ready;

  always_comb begin
    stat_groups_d = stat_groups_q;
    stat_hidden_d = stat_hidden_q;
    if (rec_hs) begin
      if (stat_groups_q != 16'hFFFF) begin
        stat_groups_d = stat_groups_q + 16'd1;
      end
      if (need_hide_q && (stat_hidden_q != 16'hFFFF)) begin
        stat_hidden_d = stat_hidden_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_groups_q <= 16'd0;
      stat_hidden_q <= 16'd0;
    end else begin
      stat_groups_q <= stat_groups_d;
      stat_hidden_q <= stat_hidden_d;
    end
  end

  assign stat_groups = stat_groups_q;
  assign stat_hidden = stat_hidden_q;
`else
  assign stat_groups = 16'd0;
  assign stat_hidden = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbh_cg_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_sbh_cg_sequencer
// Brief    : Self-checking bench for sbh_cg_sequencer with a behavioural group
//            model and a configurable-latency decision responder.
// Revision : 1.0 - initial release
// =============================================================================
module tb_sbh_cg_sequencer;

  localparam int LEVEL_W = 16;
  localparam int TO      = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coef_valid = 1'b0;
  logic               coef_ready;
  logic [LEVEL_W-1:0] coef_abs = '0;
  logic               coef_sign = 1'b0;
  logic               dec_valid_o;
  logic [3:0]         dec_firstNZ_o;
  logic [3:0]         dec_lastNZ_o;
  logic               dec_parity_o;
  logic               dec_sign_o;
  logic               dec_valid_i = 1'b0;
  logic               dec_needHide_i = 1'b0;
  logic               grp_valid;
  logic               grp_ready = 1'b0;
  logic               grp_needHide;
  logic               grp_allzero;
  logic               grp_err;
  logic [3:0]         grp_hidePos;
  logic [15:0]        stat_groups;
  logic [15:0]        stat_hidden;

  sbh_cg_sequencer #(.LEVEL_W(LEVEL_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_abs(coef_abs), .coef_sign(coef_sign),
    .dec_valid_o(dec_valid_o), .dec_firstNZ_o(dec_firstNZ_o),
    .dec_lastNZ_o(dec_lastNZ_o), .dec_parity_o(dec_parity_o),
    .dec_sign_o(dec_sign_o), .dec_valid_i(dec_valid_i),
    .dec_needHide_i(dec_needHide_i),
    .grp_valid(grp_valid), .grp_ready(grp_ready),
    .grp_needHide(grp_needHide), .grp_allzero(grp_allzero),
    .grp_err(grp_err), .grp_hidePos(grp_hidePos),
    .stat_groups(stat_groups), .stat_hidden(stat_hidden)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_groups = 0;
  int exp_hidden = 0;

  logic [51:0] all_out;
  assign all_out = {coef_ready, dec_valid_o, dec_firstNZ_o, dec_lastNZ_o, dec_parity_o,
                    dec_sign_o, grp_valid, grp_needHide, grp_allzero, grp_err,
                    grp_hidePos, stat_groups, stat_hidden};

  // Decision unit stand-in: answers dm_delay cycles after seeing a request
  logic dm_respond = 1'b0;
  int   dm_delay   = 2;
  logic dm_hide    = 1'b0;

  always begin
    @(negedge clk);
    if (dec_valid_o === 1'b1 && dm_respond) begin
      repeat (dm_delay) @(posedge clk);
      #1 dec_valid_i = 1'b1;
      dec_needHide_i = dm_hide;
      @(posedge clk);
      #1 dec_valid_i = 1'b0;
      dec_needHide_i = 1'b0;
    end
  end

  logic [LEVEL_W-1:0] g_lv [16];
  logic               g_sg [16];

  task automatic clear_group();
    for (int i = 0; i < 16; i++) begin
      g_lv[i] = '0;
      g_sg[i] = 1'b0;
    end
  endtask

  // Drives g_lv/g_sg as one group and checks the resulting request and record.
  task automatic run_group(input bit resp, input int d, input bit hide,
                           input int hold, input bit gaps);
    int   first, last, lat, n, w;
    logic par, sgn, az, ok_resp, e_err, e_nh;
    logic [3:0] e_hp;
    first = 0; last = 0; par = 1'b0; sgn = 1'b0; az = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (g_lv[i] != '0) begin
        if (az) first = i;
        az   = 1'b0;
        last = i;
        sgn  = g_sg[i];
      end
      par ^= g_lv[i][0];
    end
    ok_resp = resp && (d <= TO);
    e_err   = !az && !ok_resp;
    e_nh    = !az && ok_resp && hide;
    e_hp    = e_nh ? 4'(first) : 4'd0;
    lat     = az ? 0 : (ok_resp ? d + 1 : TO + 1);
    dm_respond = resp; dm_delay = d; dm_hide = hide;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        coef_valid = 1'b0;
        @(negedge clk);
      end
      coef_valid = 1'b1; coef_abs = g_lv[i]; coef_sign = g_sg[i];
      w = 0;
      while (coef_ready !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        checks++; errors++;
        $display("FAIL coef_ready_wait: coef_ready=%b never rose, required 1", coef_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    coef_valid = 1'b0; coef_abs = '0; coef_sign = 1'b0;

    n = 0;
    while (grp_valid !== 1'b1 && n <= TO + 3) begin
      checks++;
      if (dec_valid_o !== ((n == 0) && !az)) begin
        errors++;
        $display("FAIL dec_valid_o cyc%0d: got %b required %b", n, dec_valid_o, (n == 0) && !az);
      end
      checks++;
      if (coef_ready !== 1'b0) begin
        errors++;
        $display("FAIL coef_ready_busy cyc%0d: got %b required 0", n, coef_ready);
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    checks++;
    if (grp_valid !== 1'b1 || n != lat) begin
      errors++;
      $display("FAIL grp_latency: grp_valid=%b after %0d cycles, required 1 after %0d", grp_valid, n, lat);
    end
    checks++;
    if (dec_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL dec_valid_in_output: got %b required 0", dec_valid_o);
    end
    if (!az) begin
      checks++;
      if (dec_firstNZ_o !== 4'(first) || dec_lastNZ_o !== 4'(last) ||
          dec_parity_o !== par || dec_sign_o !== sgn) begin
        errors++;
        $display("FAIL dec_fields: first=%0d last=%0d par=%b sign=%b required %0d %0d %b %b",
                 dec_firstNZ_o, dec_lastNZ_o, dec_parity_o, dec_sign_o, first, last, par, sgn);
      end
    end
    checks++;
    if (grp_needHide !== e_nh || grp_allzero !== az || grp_err !== e_err || grp_hidePos !== e_hp) begin
      errors++;
      $display("FAIL grp_record: nh=%b az=%b err=%b pos=%0d required %b %b %b %0d",
               grp_needHide, grp_allzero, grp_err, grp_hidePos, e_nh, az, e_err, e_hp);
    end

    for (int h = 0; h < hold; h++) begin
      grp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (grp_valid !== 1'b1 || coef_ready !== 1'b0 || grp_needHide !== e_nh ||
          grp_allzero !== az || grp_err !== e_err || grp_hidePos !== e_hp) begin
        errors++;
        $display("FAIL grp_hold h%0d: valid=%b rdy=%b nh=%b az=%b err=%b pos=%0d required 1 0 %b %b %b %0d",
                 h, grp_valid, coef_ready, grp_needHide, grp_allzero, grp_err, grp_hidePos,
                 e_nh, az, e_err, e_hp);
      end
    end

    grp_ready = 1'b1;
    @(posedge clk);
    exp_groups++;
    if (e_nh) exp_hidden++;
    @(negedge clk);
    grp_ready = 1'b0;
    checks++;
    if (grp_valid !== 1'b0 || coef_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: grp_valid=%b coef_ready=%b required 0 1", grp_valid, coef_ready);
    end
  endtask

  task automatic check_stats(input string tag);
    logic [15:0] eg, eh;
`ifdef SBH_SEQ_STATS_EN
    eg = 16'(exp_groups); eh = 16'(exp_hidden);
`else
    eg = 16'd0; eh = 16'd0;
`endif
    checks++;
    if (stat_groups !== eg || stat_hidden !== eh) begin
      errors++;
      $display("FAIL stats_%s: groups=%0d hidden=%0d required %0d %0d", tag, stat_groups, stat_hidden, eg, eh);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (all_out !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (coef_ready !== 1'b1 || grp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: coef_ready=%b grp_valid=%b required 1 0", coef_ready, grp_valid);
    end
  endtask

  task automatic test_basic();
    clear_group();
    g_lv[2] = 16'd3; g_lv[5] = 16'd1; g_lv[9] = 16'd2; g_sg[9] = 1'b1;
    run_group(1'b1, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_allzero();
    clear_group();
    for (int i = 0; i < 16; i++) g_sg[i] = 1'($urandom_range(0, 1));
    run_group(1'b1, 2, 1'b1, 1, 1'b0);
  endtask

  task automatic test_hide_hold();
    clear_group();
    g_lv[4] = 16'hFFFF; g_sg[4] = 1'b1; g_lv[11] = 16'd6; g_sg[11] = 1'b0; g_lv[13] = 16'd7;
    run_group(1'b1, 2, 1'b1, 5, 1'b0);
  endtask

  task automatic test_timeout();
    clear_group();
    g_lv[7] = 16'd5; g_sg[7] = 1'b1;
    run_group(1'b0, 0, 1'b1, 2, 1'b0);
    // late response lands while the record is held
    clear_group();
    g_lv[0] = 16'd2; g_lv[3] = 16'd1; g_sg[3] = 1'b1;
    run_group(1'b1, 10, 1'b1, 5, 1'b0);
    // late response lands after the record is gone, during the next scan
    clear_group();
    g_lv[12] = 16'd9;
    run_group(1'b1, 12, 1'b1, 0, 1'b0);
    clear_group();
    g_lv[1] = 16'd4; g_lv[14] = 16'd3; g_sg[14] = 1'b1;
    run_group(1'b1, 2, 1'b1, 0, 1'b0);
  endtask

  task automatic test_boundaries();
    clear_group();
    g_lv[15] = 16'd1; g_sg[15] = 1'b1;
    run_group(1'b1, TO, 1'b1, 0, 1'b0);
    clear_group();
    g_lv[0] = 16'd8;
    run_group(1'b1, TO + 1, 1'b1, 0, 1'b0);
    clear_group();
    g_lv[0] = 16'd1; g_sg[0] = 1'b1;
    run_group(1'b1, 1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_midgroup();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      coef_valid = 1'b1; coef_abs = (i == 1) ? 16'd3 : 16'd0; coef_sign = (i == 1);
      @(posedge clk);
    end
    @(negedge clk);
    coef_valid = 1'b0; coef_abs = '0; coef_sign = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== 52'd0) begin
      errors++;
      $display("FAIL midgroup_reset_outputs: got %h required 0", all_out);
    end
    exp_groups = 0; exp_hidden = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_group();
    g_lv[6] = 16'd2; g_lv[10] = 16'd4; g_sg[10] = 1'b1;
    run_group(1'b1, 2, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stats();
    int b;
    b = exp_groups;
    for (int k = 0; k < 3; k++) begin
      clear_group();
      g_lv[k + 2] = 16'd5; g_lv[k + 8] = 16'd2;
      run_group(1'b1, 2, (k != 1), 0, 1'b0);
    end
    check_stats("three_groups");
  endtask

  task automatic test_random();
    for (int g = 0; g < 10; g++) begin
      clear_group();
      if ($urandom_range(0, 4) != 0) begin
        for (int i = 0; i < 16; i++) begin
          if ($urandom_range(0, 2) == 0) g_lv[i] = LEVEL_W'($urandom_range(1, 65535));
          g_sg[i] = 1'($urandom_range(0, 1));
        end
      end
      run_group(1'($urandom_range(0, 5) != 0), $urandom_range(1, TO + 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
    end
    check_stats("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_allzero();
    test_hide_hold();
    test_timeout();
    test_boundaries();
    test_reset_midgroup();
    test_stats();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
